sprite_layer_compositor: RTL and testbench
==========================================

Name: sprite_layer_compositor

Overview:
- Parametrised N-channel sprite selector/compositor for the VGA pipeline; successor to the two-sprite player selector.
- Sits between the sprite ROM blocks and the VGA colour output.
- Takes per-channel visible/rgb from N_CH sprite blocks and produces one registered visible/rgb pair.
- Supports four modes: off, single channel, priority overlay, auto-cycle.
- Mode/channel changes arrive through a valid/ready handshake and take effect only at a frame boundary, so a frame never tears.

Parameters:
- N_CH, 4, number of sprite channels (2..16)
- RGB_W, 24, colour width per channel
- IDX_W, 4, channel index width; must satisfy 2**IDX_W >= N_CH
- BG_COLOR, 24'h000000, rgb driven whenever visible=0
- CYCLE_FRAMES, 60, frames per channel step in auto-cycle mode (>=1)

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous active-high reset
- frame_start  in  1  one-cycle pulse at pixel (0,0) of each frame
- sel_valid  in  1  selection request valid
- sel_ready  out  1  high when no request is pending
- sel_mode  in  2  requested mode: 00 off, 01 single, 10 priority, 11 auto-cycle
- sel_idx  in  IDX_W  requested channel (single mode; start channel for auto-cycle)
- spr_visible  in  N_CH  per-channel pixel-visible flags
- spr_rgb  in  N_CH*RGB_W  per-channel colour; channel k occupies bits [k*RGB_W +: RGB_W]
- visible  out  1  registered composite visible flag
- rgb  out  RGB_W  registered composite colour
- active_mode  out  2  mode currently in effect
- active_idx  out  IDX_W  channel currently in effect

Behaviour:
Interface and reset:
- One clock, clk. Reset rst is asynchronous and active-high.
- Reset values: visible=0, rgb=BG_COLOR, active_mode=00, active_idx=0, sel_ready=1, pending cleared, frame counter=0.
- Reset asserted mid-frame clears immediately. No pending request survives reset.

Handshake:
- A request is accepted on a cycle with sel_valid && sel_ready.
- On acceptance, {sel_mode, sel_idx} is stored in the pending register and sel_ready drops to 0 on the next cycle.
- At the next frame_start with pending set: active_mode/active_idx load the pending values, pending clears, and sel_ready returns to 1 on the following cycle.
- Acceptance and frame_start in the same cycle: the request is not applied at that frame_start. It applies at the next frame_start.
- sel_idx >= N_CH in mode 01 or 11: applied as active_mode=00.

Datapath:
- 1-cycle latency: outputs on cycle t+1 reflect spr_* and the active_mode/active_idx values of cycle t.
- Mode 00: visible=0, rgb=BG_COLOR.
- Mode 01: visible=spr_visible[active_idx]; rgb = that channel's rgb if visible, else BG_COLOR.
- Mode 10: the lowest-index channel with spr_visible=1 wins. If no channel is visible: visible=0, rgb=BG_COLOR.
- Mode 11: datapath identical to mode 01.
- Frame counter, mode 11 only: increments on each frame_start.
  - When it reaches CYCLE_FRAMES: active_idx advances by 1, wrapping N_CH-1 -> 0, and the counter returns to 0.
  - A pending request applied on the same frame_start takes precedence: active_idx loads the pending value and the counter returns to 0.
- Frame counter is held at 0 in modes other than 11.
- rgb never holds a stale colour. Whenever visible=0, rgb=BG_COLOR.

Test Plan:
- Reset: assert rst mid-frame with spr_visible=4'b1111 -> next edge visible=0, rgb=BG_COLOR, active_mode=00, sel_ready=1.
- Single mode: request mode=01, idx=2, then pulse frame_start. spr_visible=4'b0100, ch2 rgb=24'hFF8000 -> one cycle later visible=1, rgb=24'hFF8000. With ch2 invisible -> visible=0, rgb=24'h000000.
- Frame-boundary and handshake: request accepted mid-frame -> sel_ready=0, outputs unchanged until the next frame_start.
  - Request and frame_start in the same cycle -> applied only at the following frame_start.
  - sel_valid held while sel_ready=0 -> ignored.
- Priority mode: spr_visible=4'b1010 with ch1=24'h00FF00, ch3=24'h0000FF -> rgb=24'h00FF00. spr_visible=0 -> visible=0, rgb=BG_COLOR.
- Auto-cycle with CYCLE_FRAMES=2, N_CH=4, start idx=3: after 2 frame_starts active_idx=0, after 4 more active_idx=2. A new request on a step frame overrides the step.
- Out-of-range: mode=01, idx=5 with N_CH=4 -> active_mode=00 after frame_start, visible=0.

Source files
------------

// File: rtl/sprite_layer_compositor.sv
// sprite_layer_compositor
// Selects or overlays one of N_CH sprite channels onto the VGA colour path.
// Mode/channel requests are taken through a valid/ready handshake, held in a
// pending register and only made active at a frame_start, so a frame never
// mixes two selections.
//
// Ports:
//   clk, rst                 pixel clock, async active-high reset
//   frame_start              one-cycle pulse at pixel (0,0)
//   sel_valid/sel_ready      request handshake (ready high when nothing pending)
//   sel_mode, sel_idx        requested mode (00 off, 01 single, 10 priority,
//                            11 auto-cycle) and channel
//   spr_visible, spr_rgb     per-channel visible flag / colour (channel k at
//                            bits [k*RGB_W +: RGB_W])
//   visible, rgb             registered composite pixel (1-cycle latency)
//   active_mode, active_idx  selection currently in effect
module sprite_layer_compositor #(
    parameter int unsigned      N_CH         = 4,
    parameter int unsigned      RGB_W        = 24,
    parameter int unsigned      IDX_W        = 4,
    parameter logic [RGB_W-1:0] BG_COLOR     = '0,
    parameter int unsigned      CYCLE_FRAMES = 60
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   frame_start,
    input  logic                   sel_valid,
    output logic                   sel_ready,
    input  logic [1:0]             sel_mode,
    input  logic [IDX_W-1:0]       sel_idx,
    input  logic [N_CH-1:0]        spr_visible,
    input  logic [N_CH*RGB_W-1:0]  spr_rgb,
    output logic                   visible,
    output logic [RGB_W-1:0]       rgb,
    output logic [1:0]             active_mode,
    output logic [IDX_W-1:0]       active_idx
);

    localparam int unsigned CNT_W  = $clog2(CYCLE_FRAMES + 1);
    localparam int unsigned IDXE_W = IDX_W + 1;

    typedef enum logic [1:0] {
        MODE_OFF    = 2'b00,
        MODE_SINGLE = 2'b01,
        MODE_PRIO   = 2'b10,
        MODE_AUTO   = 2'b11
    } mode_e;

    mode_e             active_mode_q, active_mode_d;
    logic [IDX_W-1:0]  active_idx_q,  active_idx_d;
    logic              pend_valid_q,  pend_valid_d;
    mode_e             pend_mode_q,   pend_mode_d;
    logic [IDX_W-1:0]  pend_idx_q,    pend_idx_d;
    logic [CNT_W-1:0]  frame_cnt_q,   frame_cnt_d;
    logic              visible_q,     visible_d;
    logic [RGB_W-1:0]  rgb_q,         rgb_d;

    logic              pend_oor_c;
    logic [CNT_W-1:0]  frame_cnt_inc_c;
    logic [IDX_W-1:0]  idx_next_c;

    // Widened compare so N_CH == 2**IDX_W does not wrap to zero
    assign pend_oor_c      = {1'b0, pend_idx_q} >= IDXE_W'(N_CH);
    assign frame_cnt_inc_c = frame_cnt_q + CNT_W'(1);
    assign idx_next_c      = (active_idx_q == IDX_W'(N_CH - 1)) ? '0
                                                                 : active_idx_q + IDX_W'(1);

    // Handshake, frame-boundary apply and auto-cycle stepping
    always_comb begin
        active_mode_d = active_mode_q;
        active_idx_d  = active_idx_q;
        pend_valid_d  = pend_valid_q;
        pend_mode_d   = pend_mode_q;
        pend_idx_d    = pend_idx_q;
        frame_cnt_d   = (active_mode_q == MODE_AUTO) ? frame_cnt_q : '0;

        if (frame_start) begin
            if (pend_valid_q) begin
                // A pending request wins over an auto-cycle step on the same frame
                pend_valid_d = 1'b0;
                frame_cnt_d  = '0;
                if ((pend_mode_q == MODE_SINGLE || pend_mode_q == MODE_AUTO) && pend_oor_c) begin
                    // Invalid channel: fall back to off with a clean index
                    active_mode_d = MODE_OFF;
                    active_idx_d  = '0;
                end else begin
                    active_mode_d = pend_mode_q;
                    active_idx_d  = pend_idx_q;
                end
            end else if (active_mode_q == MODE_AUTO) begin
                if (frame_cnt_inc_c == CNT_W'(CYCLE_FRAMES)) begin
                    frame_cnt_d  = '0;
                    active_idx_d = idx_next_c;
                end else begin
                    frame_cnt_d  = frame_cnt_inc_c;
                end
            end
        end

        // Acceptance uses the pre-edge pending flag, so a request arriving
        // with frame_start waits for the following frame
        if (sel_valid && !pend_valid_q) begin
            pend_valid_d = 1'b1;
            pend_mode_d  = mode_e'(sel_mode);
            pend_idx_d   = sel_idx;
        end
    end

    // Pixel composite from the selection in effect this cycle
    always_comb begin
        visible_d = 1'b0;
        rgb_d     = BG_COLOR;
        case (active_mode_q)
            MODE_SINGLE, MODE_AUTO: begin
                for (int unsigned k = 0; k < N_CH; k++) begin
                    if (IDX_W'(k) == active_idx_q && spr_visible[k]) begin
                        visible_d = 1'b1;
                        rgb_d     = spr_rgb[k*RGB_W +: RGB_W];
                    end
                end
            end
            MODE_PRIO: begin
                // Scan high to low so the lowest visible channel is written last
                for (int k = int'(N_CH) - 1; k >= 0; k--) begin
                    if (spr_visible[k]) begin
                        visible_d = 1'b1;
                        rgb_d     = spr_rgb[k*RGB_W +: RGB_W];
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_mode_q <= MODE_OFF;
            active_idx_q  <= '0;
            pend_valid_q  <= 1'b0;
            pend_mode_q   <= MODE_OFF;
            pend_idx_q    <= '0;
            frame_cnt_q   <= '0;
            visible_q     <= 1'b0;
            rgb_q         <= BG_COLOR;
        end else begin
            active_mode_q <= active_mode_d;
            active_idx_q  <= active_idx_d;
            pend_valid_q  <= pend_valid_d;
            pend_mode_q   <= pend_mode_d;
            pend_idx_q    <= pend_idx_d;
            frame_cnt_q   <= frame_cnt_d;
            visible_q     <= visible_d;
            rgb_q         <= rgb_d;
        end
    end

    assign sel_ready   = ~pend_valid_q;
    assign visible     = visible_q;
    assign rgb         = rgb_q;
    assign active_mode = active_mode_q;
    assign active_idx  = active_idx_q;

endmodule

// File: tb/tb_sprite_layer_compositor.sv
// Testbench for sprite_layer_compositor: directed vector table, hand-written
// auto-cycle and reset sequences, then randomized traffic against a model.
module tb_sprite_layer_compositor;

    localparam int unsigned N_CH  = 4;
    localparam int unsigned RGB_W = 24;
    localparam int unsigned IDX_W = 4;
    localparam int unsigned CYC_F = 2;
    localparam logic [23:0] BG    = 24'h0A0B0C;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  frame_start;
    logic                  sel_valid;
    logic                  sel_ready;
    logic [1:0]            sel_mode;
    logic [IDX_W-1:0]      sel_idx;
    logic [N_CH-1:0]       spr_visible;
    logic [N_CH*RGB_W-1:0] spr_rgb;
    logic                  visible;
    logic [RGB_W-1:0]      rgb;
    logic [1:0]            active_mode;
    logic [IDX_W-1:0]      active_idx;

    int checks = 0;
    int errors = 0;

    sprite_layer_compositor #(
        .N_CH(N_CH), .RGB_W(RGB_W), .IDX_W(IDX_W),
        .BG_COLOR(BG), .CYCLE_FRAMES(CYC_F)
    ) dut (
        .clk(clk), .rst(rst), .frame_start(frame_start),
        .sel_valid(sel_valid), .sel_ready(sel_ready),
        .sel_mode(sel_mode), .sel_idx(sel_idx),
        .spr_visible(spr_visible), .spr_rgb(spr_rgb),
        .visible(visible), .rgb(rgb),
        .active_mode(active_mode), .active_idx(active_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        sv;
        logic [1:0]  sm;
        logic [3:0]  si;
        logic        fs;
        logic [3:0]  vis;
        logic        e_vis;
        logic [23:0] e_rgb;
        logic [1:0]  e_mode;
        logic [3:0]  e_idx;
        logic        e_rdy;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ev, input logic [23:0] er,
                           input logic [1:0] em, input logic [3:0] ei, input logic erdy);
        chk({tag, ".visible"},     32'(visible),     32'(ev));
        chk({tag, ".rgb"},         32'(rgb),         32'(er));
        chk({tag, ".active_mode"}, 32'(active_mode), 32'(em));
        chk({tag, ".active_idx"},  32'(active_idx),  32'(ei));
        chk({tag, ".sel_ready"},   32'(sel_ready),   32'(erdy));
    endtask

    // Drive one cycle of inputs, step past the edge, release the strobes
    task automatic cyc(input logic v, input logic [1:0] m, input logic [3:0] i,
                       input logic f, input logic [3:0] sp);
        sel_valid   = v;
        sel_mode    = m;
        sel_idx     = i;
        frame_start = f;
        spr_visible = sp;
        @(posedge clk);
        #1;
        sel_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic frame();
        cyc(1'b0, 2'd0, 4'd0, 1'b1, 4'b0000);
        cyc(1'b0, 2'd0, 4'd0, 1'b0, 4'b0000);
    endtask

    // Reference model state (selection rules, not RTL structure)
    int          m_mode, m_idx, m_cnt, p_mode, p_idx;
    bit          m_pend;

    initial begin
        logic [23:0] ch_rgb [4];
        bit          ev;
        logic [23:0] er;
        bit          was_ready;
        logic        rv, rf;
        logic [1:0]  rm;
        logic [3:0]  ri, rsp;

        vecs[0]  = '{1'b1, 2'd1, 4'd2, 1'b0, 4'b0100, 1'b0, BG,        2'd0, 4'd0, 1'b0};
        vecs[1]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b0100, 1'b0, BG,        2'd0, 4'd0, 1'b0};
        vecs[2]  = '{1'b1, 2'd2, 4'd0, 1'b0, 4'b0100, 1'b0, BG,        2'd0, 4'd0, 1'b0};
        vecs[3]  = '{1'b0, 2'd0, 4'd0, 1'b1, 4'b0100, 1'b0, BG,        2'd1, 4'd2, 1'b1};
        vecs[4]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b0100, 1'b1, 24'hFF8000, 2'd1, 4'd2, 1'b1};
        vecs[5]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b1011, 1'b0, BG,        2'd1, 4'd2, 1'b1};
        vecs[6]  = '{1'b1, 2'd2, 4'd0, 1'b1, 4'b0100, 1'b1, 24'hFF8000, 2'd1, 4'd2, 1'b0};
        vecs[7]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b0100, 1'b1, 24'hFF8000, 2'd1, 4'd2, 1'b0};
        vecs[8]  = '{1'b0, 2'd0, 4'd0, 1'b1, 4'b1010, 1'b0, BG,        2'd2, 4'd0, 1'b1};
        vecs[9]  = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b1010, 1'b1, 24'h00FF00, 2'd2, 4'd0, 1'b1};
        vecs[10] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b0000, 1'b0, BG,        2'd2, 4'd0, 1'b1};
        vecs[11] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b1111, 1'b1, 24'h112233, 2'd2, 4'd0, 1'b1};
        vecs[12] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b1000, 1'b1, 24'h0000FF, 2'd2, 4'd0, 1'b1};
        vecs[13] = '{1'b1, 2'd1, 4'd5, 1'b0, 4'b1000, 1'b1, 24'h0000FF, 2'd2, 4'd0, 1'b0};
        vecs[14] = '{1'b0, 2'd0, 4'd0, 1'b1, 4'b1111, 1'b1, 24'h112233, 2'd0, 4'd0, 1'b1};
        vecs[15] = '{1'b0, 2'd0, 4'd0, 1'b0, 4'b1111, 1'b0, BG,        2'd0, 4'd0, 1'b1};

        rst = 1'b1; frame_start = 1'b0; sel_valid = 1'b0; sel_mode = 2'd0; sel_idx = '0;
        spr_visible = '0;
        spr_rgb = {24'h0000FF, 24'hFF8000, 24'h00FF00, 24'h112233};
        repeat (3) @(posedge clk);
        #1;
        chk_all("reset", 1'b0, BG, 2'd0, 4'd0, 1'b1);
        rst = 1'b0;

        // Directed vector table
        for (int r = 0; r < 16; r++) begin
            cyc(vecs[r].sv, vecs[r].sm, vecs[r].si, vecs[r].fs, vecs[r].vis);
            chk_all($sformatf("row%0d", r), vecs[r].e_vis, vecs[r].e_rgb,
                    vecs[r].e_mode, vecs[r].e_idx, vecs[r].e_rdy);
        end

        // Auto-cycle from channel 3 with a two-frame step
        cyc(1'b1, 2'd3, 4'd3, 1'b0, 4'b0000);
        cyc(1'b0, 2'd0, 4'd0, 1'b1, 4'b0000);
        chk("auto.start_idx", 32'(active_idx), 32'd3);
        chk("auto.start_mode", 32'(active_mode), 32'd3);
        frame();
        chk("auto.after1_idx", 32'(active_idx), 32'd3);
        frame();
        chk("auto.after2_idx", 32'(active_idx), 32'd0);
        cyc(1'b0, 2'd0, 4'd0, 1'b0, 4'b0001);
        chk("auto.pix_visible", 32'(visible), 32'd1);
        chk("auto.pix_rgb", 32'(rgb), 32'h112233);
        repeat (4) frame();
        chk("auto.after6_idx", 32'(active_idx), 32'd2);
        frame();
        chk("auto.mid_idx", 32'(active_idx), 32'd2);
        cyc(1'b1, 2'd3, 4'd1, 1'b0, 4'b0000);
        chk("auto.req_ready", 32'(sel_ready), 32'd0);
        frame();
        chk("auto.override_idx", 32'(active_idx), 32'd1);
        chk("auto.override_ready", 32'(sel_ready), 32'd1);
        frame();
        chk("auto.post_override1", 32'(active_idx), 32'd1);
        frame();
        chk("auto.post_override2", 32'(active_idx), 32'd2);

        // Reset asserted mid-frame with a request pending and all channels visible
        cyc(1'b1, 2'd1, 4'd2, 1'b0, 4'b1111);
        chk("rst.pre_visible", 32'(visible), 32'd1);
        chk("rst.pre_ready", 32'(sel_ready), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk_all("rst.async", 1'b0, BG, 2'd0, 4'd0, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b0, 2'd0, 4'd0, 1'b1, 4'b1111);
        cyc(1'b0, 2'd0, 4'd0, 1'b0, 4'b1111);
        chk_all("rst.no_pending", 1'b0, BG, 2'd0, 4'd0, 1'b1);

        // Randomized traffic against the reference model
        m_mode = 0; m_idx = 0; m_cnt = 0; m_pend = 1'b0; p_mode = 0; p_idx = 0;
        for (int n = 0; n < 2000; n++) begin
            rv  = ($urandom_range(0, 3) == 0);
            rm  = 2'($urandom_range(0, 3));
            ri  = 4'($urandom_range(0, 5));
            rf  = ($urandom_range(0, 7) == 0);
            rsp = 4'($urandom_range(0, 15));
            for (int k = 0; k < 4; k++) ch_rgb[k] = 24'($urandom);
            spr_rgb = {ch_rgb[3], ch_rgb[2], ch_rgb[1], ch_rgb[0]};

            ev = 1'b0;
            er = BG;
            if (m_mode == 1 || m_mode == 3) begin
                if (rsp[m_idx]) begin ev = 1'b1; er = ch_rgb[m_idx]; end
            end else if (m_mode == 2) begin
                for (int k = 3; k >= 0; k--)
                    if (rsp[k]) begin ev = 1'b1; er = ch_rgb[k]; end
            end

            was_ready = !m_pend;
            if (rf) begin
                if (m_pend) begin
                    m_pend = 1'b0;
                    m_cnt  = 0;
                    if ((p_mode == 1 || p_mode == 3) && p_idx >= int'(N_CH)) begin
                        m_mode = 0; m_idx = 0;
                    end else begin
                        m_mode = p_mode; m_idx = p_idx;
                    end
                end else if (m_mode == 3) begin
                    m_cnt++;
                    if (m_cnt == int'(CYC_F)) begin
                        m_cnt = 0;
                        m_idx = (m_idx + 1) % int'(N_CH);
                    end
                end
            end
            if (rv && was_ready) begin
                m_pend = 1'b1; p_mode = int'(rm); p_idx = int'(ri);
            end

            cyc(rv, rm, ri, rf, rsp);
            chk_all($sformatf("rand%0d", n), ev, er, 2'(m_mode), 4'(m_idx), !m_pend);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
